lsu_mem_ctrl: RTL and testbench

Load/store unit between the execute stage and the 64-bit byte-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and supports byte, half, word and doubleword sizes. Loads are aligned, extracted and sign- or zero-extended. The memory has no byte enables, so sub-doubleword stores use a read-modify-write sequence, and each access ends with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_load_format.sv | 26 ++
 rtl/lsu_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encoding, FSM states and
// the offset alignment mask helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    localparam logic [2:0] ALIGN_MASK = 3'b111;

    // Offset bits that may legally be set for an access of this size.
    function automatic logic [2:0] size_off_mask(input lsu_size_e sz);
        return ALIGN_MASK << sz;
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load data formatter: shifts the addressed field down from the captured
// doubleword and sign- or zero-extends it to 64 bits.
module lsu_load_format
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  off,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    output logic [63:0] rdata
);

    logic [63:0] field;

    always_comb begin
        field = data >> {off, 3'b000};
        rdata = field;
        case (size)
            SZ_B:    rdata = {{56{~is_unsigned & field[7]}},  field[7:0]};
            SZ_H:    rdata = {{48{~is_unsigned & field[15]}}, field[15:0]};
            SZ_W:    rdata = {{32{~is_unsigned & field[31]}}, field[31:0]};
            default: rdata = field;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of a 64-bit memory without byte enables; narrow
// stores use read-modify-write. `LSU_MISALIGN_TRAP_EN enables misalignment faults.
module lsu_mem_ctrl
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [63:0] mem_rdata,
    output lsu_state_e  state_dbg
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // req_ready is high only in IDLE, and req_valid elsewhere is ignored.

    lsu_state_e  state_q, state_d;
    logic [63:3] addr_q;
    logic [63:0] data_q, wdata_q, merged, wdata_shift, fmt_rdata;
    lsu_size_e   size_q, req_sz;
    logic [2:0]  off_q, req_off;
    logic [7:0]  lane_mask;
    logic        uns_q, write_q, fault_q, misaligned;

    assign req_sz = lsu_size_e'(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = |(req_addr[2:0] & ~size_off_mask(req_sz));
    assign req_off    = req_addr[2:0];
`else
    assign misaligned = 1'b0;
    assign req_off    = req_addr[2:0] & size_off_mask(req_sz);
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned)       state_d = RESP;
                    else if (!req_write)  state_d = READ;
                    else if (req_sz == SZ_D) state_d = WRITE;
                    else                  state_d = RMW_RD;
                end
            end
            READ: begin
                mem_read = 1'b1;
                state_d  = RESP;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_write = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A reset landing mid-access must never reach the memory.
        mem_read  = mem_read & ~reset;
        mem_write = mem_write & ~reset;
    end

    // Byte lanes off..off+n-1 take store data; the rest keep the memory value.
    always_comb begin
        lane_mask   = ((8'd1 << (4'd1 << size_q)) - 8'd1) << off_q;
        wdata_shift = wdata_q << {off_q, 3'b000};
        merged      = mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (lane_mask[i]) merged[8*i +: 8] = wdata_shift[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_B;
            off_q   <= '0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[63:3];
                        data_q  <= req_wdata;
                        wdata_q <= req_wdata;
                        size_q  <= req_sz;
                        off_q   <= req_off;
                        uns_q   <= req_unsigned;
                        write_q <= req_write;
                        fault_q <= misaligned;
                    end
                end
                READ:    data_q <= mem_rdata;
                RMW_RD:  data_q <= merged;
                default: ;
            endcase
        end
    end

    lsu_load_format u_load_format (
        .data        (data_q),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (fmt_rdata)
    );

    assign mem_addr   = {addr_q, 3'b000};
    assign mem_wdata  = data_q;
    assign resp_fault = (state_q == RESP) && fault_q;
    assign resp_rdata = (state_q == RESP && !write_q && !fault_q) ? fmt_rdata : '0;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-level reference memory model,
// directed cases from the test plan, then randomized requests.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;
    lsu_state_e  state_dbg;

    logic [63:0] mem [16];
    logic [7:0]  ref_mem [128];
    logic [63:0] exp_q [$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .state_dbg    (state_dbg)
    );

    // Memory device: combinational read, 8-byte write at posedge.
    assign mem_rdata = mem[mem_addr[6:3]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[6:3]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge and follow it to its response pulse.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [6:0] addr, input logic [63:0] wd, input bit hold,
                          output int waited, output logic [63:0] got_rd, output logic [63:0] got_wd);
        int n, base, wbase, lat, nrd, nwr, erd, ewr, k;
        bit flt, seen;
        logic [63:0] v, word;
        n     = 1 << sz;
        base  = int'(addr) - (int'(addr) % n);
        wbase = int'(addr) - (int'(addr) % 8);
        flt   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        flt = (int'(addr) % n) != 0;
`endif
        v = '0;
        if (!flt && !wr) begin
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
            if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        end
        word = '0;
        if (!flt && wr) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
            for (int i = 0; i < 8; i++) word[8*i +: 8] = ref_mem[wbase + i];
        end
        exp_q.push_back(v);
        lat = flt ? 1 : ((wr && n < 8) ? 3 : 2);
        erd = (flt || (wr && n == 8)) ? 0 : 1;
        ewr = (!flt && wr) ? 1 : 0;

        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = {57'd0, addr}; req_wdata = wd;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        nrd = 0; nwr = 0; seen = 1'b0; got_rd = '0; got_wd = '0; k = 1;
        while (!seen && k <= 8) begin
            if (mem_read) begin
                nrd++;
                check("rd_addr", mem_addr, 64'(wbase));
            end
            if (mem_write) begin
                nwr++;
                got_wd = mem_wdata;
                check("wr_addr", mem_addr, 64'(wbase));
                check("wr_data", mem_wdata, word);
            end
            if (resp_valid) begin
                seen = 1'b1;
                got_rd = resp_rdata;
                check("latency", 64'(k), 64'(lat));
                check("rdata", resp_rdata, exp_q.pop_front());
                check("fault", 64'(resp_fault), 64'(flt));
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            check("resp_timeout", 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end
        check("n_read", 64'(nrd), 64'(erd));
        check("n_write", 64'(nwr), 64'(ewr));
    endtask

    initial begin
        int w;
        logic [63:0] rd, wd;
        logic [7:0] init_bytes [16] = '{8'h83, 8'h34, 8'h05, 8'h0F, 8'hB3, 8'h84, 8'h9A, 8'h00,
                                        8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h38, 8'h95, 8'h0E};
        for (int i = 0; i < 128; i++) ref_mem[i] = (i < 16) ? init_bytes[i] : 8'($urandom);
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < 8; b++) mem[i][8*b +: 8] = ref_mem[8*i + b];

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_fault", 64'(resp_fault), 64'd0);
        check("rst_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        reset = 1'b0;

        do_req(1'b0, 2'd3, 1'b0, 7'h00, '0, 1'b0, w, rd, wd);
        check("ld_0", rd, 64'h009A84B30F053483);
        do_req(1'b0, 2'd0, 1'b0, 7'h00, '0, 1'b0, w, rd, wd);
        check("lb_0", rd, 64'hFFFFFFFFFFFFFF83);
        do_req(1'b0, 2'd0, 1'b1, 7'h00, '0, 1'b0, w, rd, wd);
        check("lbu_0", rd, 64'h83);
        do_req(1'b0, 2'd1, 1'b0, 7'h04, '0, 1'b0, w, rd, wd);
        check("lh_4", rd, 64'hFFFFFFFFFFFF84B3);
        do_req(1'b0, 2'd2, 1'b0, 7'h04, '0, 1'b0, w, rd, wd);
        check("lw_4", rd, 64'h00000000009A84B3);
        do_req(1'b1, 2'd0, 1'b0, 7'h0D, 64'hAA, 1'b0, w, rd, wd);
        check("sb_merge", wd, 64'h0E95AA2300148493);
        do_req(1'b0, 2'd0, 1'b1, 7'h0D, '0, 1'b0, w, rd, wd);
        check("lbu_d", rd, 64'hAA);
        do_req(1'b0, 2'd2, 1'b0, 7'h02, '0, 1'b0, w, rd, wd);
`ifndef LSU_MISALIGN_TRAP_EN
        check("lw_2_masked", rd, 64'h0F053483);
`endif

        // Reset during the WRITE of a half store must suppress the write.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 64'h8; req_wdata = 64'hBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid_rmw_read", 64'(mem_read), 64'd1);
        @(negedge clk);
        check("rst_mid_write_pre", 64'(mem_write), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_write_gated", 64'(mem_write), 64'd0);
        @(negedge clk);
        check("rst_mid_state", 64'(state_dbg), 64'(IDLE));
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        do_req(1'b0, 2'd3, 1'b0, 7'h08, '0, 1'b0, w, rd, wd);
        check("rst_mid_mem_kept", rd, 64'h0E95AA2300148493);

        // Back-to-back with req_valid held high across the store.
        do_req(1'b1, 2'd3, 1'b0, 7'h10, 64'h1122334455667788, 1'b1, w, rd, wd);
        do_req(1'b0, 2'd3, 1'b0, 7'h10, '0, 1'b0, w, rd, wd);
        check("b2b_wait", 64'(w), 64'd1);
        check("b2b_ld", rd, 64'h1122334455667788);

        for (int t = 0; t < 60; t++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   7'($urandom_range(0, 127)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   w, rd, wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
